// File: rtl/e1_tx_feeder.sv
// E1 transmit feeder: serves framer fetch requests from a 4-entry queue of buffer indices.
// Optional E-bit accumulation is compiled in when E1_TX_FEEDER_EBIT_EN is defined.
module e1_tx_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_enable,
  input  logic        sub_valid,
  input  logic [2:0]  sub_mf,
  output logic        sub_ready,
  output logic        done_valid,
  output logic [2:0]  done_mf,
  output logic        stat_underflow,
  input  logic [3:0]  fr_frame,
  input  logic [4:0]  fr_ts,
  input  logic        fr_mf_first,
  input  logic        fr_mf_last,
  input  logic        fr_req,
  output logic [7:0]  fr_data,
  output logic [1:0]  fr_crc_e,
  output logic        fr_rdy,
  output logic        buf_rd_en,
  output logic [11:0] buf_rd_addr,
  input  logic [7:0]  buf_rd_data,
  input  logic        rx_crc_valid,
  input  logic        rx_crc_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state_q, state_d;
  logic [2:0] active_mf_q, active_mf_d;
  logic [2:0] q_mem_q [4];
  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic [2:0] count_q, count_d;

  logic       s1_req_q, s1_req_d;
  logic       s1_act_q, s1_act_d;
  logic       s1_last_q, s1_last_d;
  logic [2:0] s1_mf_q, s1_mf_d;

  logic [7:0] fr_data_q, fr_data_d;
  logic       fr_rdy_q, fr_rdy_d;
  logic       done_valid_q, done_valid_d;
  logic [2:0] done_mf_q, done_mf_d;
  logic       stat_underflow_q, stat_underflow_d;

  logic       mf_start, can_pop, pop, push, cur_active;
  logic [2:0] cur_mf;

  assign sub_ready = (count_q != 3'd4);

  // A multiframe start decides activity in the same cycle, so the first read
  // already uses the freshly popped buffer index.
  always_comb begin
    mf_start   = fr_req & fr_mf_first;
    can_pop    = ctrl_enable & (count_q != 3'd0);
    pop        = mf_start & can_pop;
    push       = sub_valid & sub_ready;
    cur_active = mf_start ? can_pop : (state_q == ACTIVE);
    cur_mf     = mf_start ? q_mem_q[head_q] : active_mf_q;
  end

  always_comb begin
    state_d          = state_q;
    active_mf_d      = active_mf_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    stat_underflow_d = mf_start & ctrl_enable & (count_q == 3'd0);

    if (mf_start) begin
      state_d = can_pop ? ACTIVE : IDLE;
      if (can_pop) active_mf_d = q_mem_q[head_q];
    end

    if (pop)  head_d = head_q + 2'd1;
    if (push) tail_d = tail_q + 2'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    buf_rd_en   = fr_req & cur_active;
    buf_rd_addr = buf_rd_en ? {cur_mf, fr_frame, fr_ts} : 12'd0;

    s1_req_d  = fr_req;
    s1_act_d  = fr_req & cur_active;
    s1_last_d = fr_req & fr_mf_last & cur_active;
    s1_mf_d   = cur_mf;

    fr_data_d = fr_data_q;
    fr_rdy_d  = fr_rdy_q;
    if (s1_req_q) begin
      fr_data_d = s1_act_q ? buf_rd_data : 8'hFF;
      fr_rdy_d  = s1_act_q;
    end

    done_valid_d = s1_last_q;
    done_mf_d    = s1_last_q ? s1_mf_q : done_mf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      active_mf_q      <= 3'd0;
      head_q           <= 2'd0;
      tail_q           <= 2'd0;
      count_q          <= 3'd0;
      s1_req_q         <= 1'b0;
      s1_act_q         <= 1'b0;
      s1_last_q        <= 1'b0;
      s1_mf_q          <= 3'd0;
      fr_data_q        <= 8'hFF;
      fr_rdy_q         <= 1'b0;
      done_valid_q     <= 1'b0;
      done_mf_q        <= 3'd0;
      stat_underflow_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      active_mf_q      <= active_mf_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      s1_req_q         <= s1_req_d;
      s1_act_q         <= s1_act_d;
      s1_last_q        <= s1_last_d;
      s1_mf_q          <= s1_mf_d;
      fr_data_q        <= fr_data_d;
      fr_rdy_q         <= fr_rdy_d;
      done_valid_q     <= done_valid_d;
      done_mf_q        <= done_mf_d;
      stat_underflow_q <= stat_underflow_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_queue
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        q_mem_q[gi] <= 3'd0;
      else if (push && (tail_q == 2'(gi)))
        q_mem_q[gi] <= sub_mf;
    end
  end

  assign fr_data        = fr_data_q;
  assign fr_rdy         = fr_rdy_q;
  assign done_valid     = done_valid_q;
  assign done_mf        = done_mf_q;
  assign stat_underflow = stat_underflow_q;

`ifdef E1_TX_FEEDER_EBIT_EN
  logic [1:0] e_acc_q, e_acc_d;
  logic [1:0] fr_crc_e_q, fr_crc_e_d;

  // A CRC result arriving on the capture cycle belongs to the new multiframe.
  always_comb begin
    e_acc_d    = e_acc_q;
    fr_crc_e_d = fr_crc_e_q;
    if (mf_start) begin
      fr_crc_e_d = e_acc_q;
      e_acc_d    = rx_crc_valid ? {1'b1, ~rx_crc_err} : 2'b11;
    end else if (rx_crc_valid) begin
      e_acc_d    = {e_acc_q[0], ~rx_crc_err};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_acc_q    <= 2'b11;
      fr_crc_e_q <= 2'b11;
    end else begin
      e_acc_q    <= e_acc_d;
      fr_crc_e_q <= fr_crc_e_d;
    end
  end

  assign fr_crc_e = fr_crc_e_q;
`else
  logic ebit_unused;
  assign ebit_unused = rx_crc_valid ^ rx_crc_err;
  assign fr_crc_e    = 2'b11;
`endif

endmodule

// File: tb/tb_e1_tx_feeder.sv
// Directed bench for e1_tx_feeder: queue service, underflow, ordering, E-bits and reset.
`timescale 1ns/1ps
module tb_e1_tx_feeder;

  logic        clk;
  logic        rst;
  logic        ctrl_enable;
  logic        sub_valid;
  logic [2:0]  sub_mf;
  logic        sub_ready;
  logic        done_valid;
  logic [2:0]  done_mf;
  logic        stat_underflow;
  logic [3:0]  fr_frame;
  logic [4:0]  fr_ts;
  logic        fr_mf_first;
  logic        fr_mf_last;
  logic        fr_req;
  logic [7:0]  fr_data;
  logic [1:0]  fr_crc_e;
  logic        fr_rdy;
  logic        buf_rd_en;
  logic [11:0] buf_rd_addr;
  logic [7:0]  buf_rd_data;
  logic        rx_crc_valid;
  logic        rx_crc_err;

  int n_total = 0;
  int n_bad   = 0;

  e1_tx_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_enable    (ctrl_enable),
    .sub_valid      (sub_valid),
    .sub_mf         (sub_mf),
    .sub_ready      (sub_ready),
    .done_valid     (done_valid),
    .done_mf        (done_mf),
    .stat_underflow (stat_underflow),
    .fr_frame       (fr_frame),
    .fr_ts          (fr_ts),
    .fr_mf_first    (fr_mf_first),
    .fr_mf_last     (fr_mf_last),
    .fr_req         (fr_req),
    .fr_data        (fr_data),
    .fr_crc_e       (fr_crc_e),
    .fr_rdy         (fr_rdy),
    .buf_rd_en      (buf_rd_en),
    .buf_rd_addr    (buf_rd_addr),
    .buf_rd_data    (buf_rd_data),
    .rx_crc_valid   (rx_crc_valid),
    .rx_crc_err     (rx_crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer RAM contents are a fixed function of the address; one-cycle read latency.
  function automatic logic [7:0] ram_f(input logic [11:0] a);
    return (a[7:0] ^ {a[11:8], a[11:8]}) + 8'h13;
  endfunction

  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= ram_f(buf_rd_addr);
  end

  function automatic logic [1:0] ecrc(input logic [1:0] v);
`ifdef E1_TX_FEEDER_EBIT_EN
    return v;
`else
    return 2'b11;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_result(input bit act, input logic [11:0] addr, input bit last,
                              input logic [2:0] mf, input logic [1:0] crc);
    check("fr_rdy", fr_rdy, act);
    check("fr_data", fr_data, act ? ram_f(addr) : 8'hFF);
    check("done_valid", done_valid, act && last);
    if (act && last) check("done_mf", done_mf, mf);
    check("fr_crc_e_hold", fr_crc_e, crc);
  endtask

  task automatic push(input logic [2:0] m, input bit exp_ready);
    @(negedge clk);
    sub_valid = 1'b1;
    sub_mf    = m;
    #1;
    check("sub_ready", sub_ready, exp_ready);
    $display("push mf=%0d ready=%0b", m, sub_ready);
    @(negedge clk);
    sub_valid = 1'b0;
  endtask

  task automatic rx_pulse(input bit err);
    @(negedge clk);
    rx_crc_valid = 1'b1;
    rx_crc_err   = err;
    @(negedge clk);
    rx_crc_valid = 1'b0;
  endtask

  // Issues fetch requests start..start+n-1 of a 512-request multiframe, one every two cycles.
  task automatic run_mf(input int start, input int n, input bit act, input logic [2:0] mf,
                        input bit uf, input logic [1:0] crc, input int en_off_at,
                        input bit rx_first, input bit rx_err);
    logic [11:0] paddr;
    bit          plast;
    bit          have;
    have  = 1'b0;
    paddr = 12'd0;
    plast = 1'b0;
    for (int i = start; i < start + n; i++) begin
      @(negedge clk);
      if (have) check_result(act, paddr, plast, mf, crc);
      fr_req      = 1'b1;
      fr_frame    = 4'(i / 32);
      fr_ts       = 5'(i % 32);
      fr_mf_first = (i == 0);
      fr_mf_last  = (i == 511);
      if (i == en_off_at) ctrl_enable = 1'b0;
      if (i == 0 && rx_first) begin
        rx_crc_valid = 1'b1;
        rx_crc_err   = rx_err;
      end
      paddr = {mf, 4'(i / 32), 5'(i % 32)};
      plast = (i == 511);
      have  = 1'b1;
      #1;
      check("buf_rd_en", buf_rd_en, act);
      if (act) check("buf_rd_addr", buf_rd_addr, paddr);
      @(negedge clk);
      fr_req       = 1'b0;
      fr_mf_first  = 1'b0;
      fr_mf_last   = 1'b0;
      rx_crc_valid = 1'b0;
      check("stat_underflow", stat_underflow, (i == 0) && uf);
      check("done_gap", done_valid, 1'b0);
      if (i == 0) check("fr_crc_e_cap", fr_crc_e, crc);
    end
    @(negedge clk);
    check_result(act, paddr, plast, mf, crc);
    $display("mf reqs %0d..%0d active=%0b mf=%0d crc_e=%0b bad_so_far=%0d",
             start, start + n - 1, act, mf, fr_crc_e, n_bad);
  endtask

  task automatic check_reset_vals(input string where);
    check({where, "_sub_ready"}, sub_ready, 1'b1);
    check({where, "_fr_data"}, fr_data, 8'hFF);
    check({where, "_fr_rdy"}, fr_rdy, 1'b0);
    check({where, "_fr_crc_e"}, fr_crc_e, 2'b11);
    check({where, "_buf_rd_en"}, buf_rd_en, 1'b0);
    check({where, "_buf_rd_addr"}, buf_rd_addr, 12'd0);
    check({where, "_done_valid"}, done_valid, 1'b0);
    check({where, "_done_mf"}, done_mf, 3'd0);
    check({where, "_stat_underflow"}, stat_underflow, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    ctrl_enable  = 1'b1;
    sub_valid    = 1'b0;
    sub_mf       = 3'd0;
    fr_frame     = 4'd0;
    fr_ts        = 5'd0;
    fr_mf_first  = 1'b0;
    fr_mf_last   = 1'b0;
    fr_req       = 1'b0;
    buf_rd_data  = 8'h00;
    rx_crc_valid = 1'b0;
    rx_crc_err   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    $display("reset checked");
    rst = 1'b0;

    // Empty queue: underflow, idle data
    run_mf(0, 512, 1'b0, 3'd0, 1'b1, ecrc(2'b11), -1, 1'b0, 1'b0);

    // Single buffer 3: addresses 0x600..0x7FF, one done
    push(3'd3, 1'b1);
    run_mf(0, 512, 1'b1, 3'd3, 1'b0, ecrc(2'b11), -1, 1'b0, 1'b0);

    // Fill queue, refuse a fifth entry, FIFO order
    push(3'd0, 1'b1);
    push(3'd1, 1'b1);
    push(3'd2, 1'b1);
    push(3'd3, 1'b1);
    push(3'd5, 1'b0);
    for (int k = 0; k < 4; k++)
      run_mf(0, 512, 1'b1, 3'(k), 1'b0, ecrc(2'b11), -1, 1'b0, 1'b0);
    run_mf(0, 512, 1'b0, 3'd0, 1'b1, ecrc(2'b11), -1, 1'b0, 1'b0);

    // E-bits: err 1 then 0 gives 01; a quiet multiframe gives 11
    rx_pulse(1'b1);
    rx_pulse(1'b0);
    push(3'd1, 1'b1);
    run_mf(0, 512, 1'b1, 3'd1, 1'b0, ecrc(2'b01), -1, 1'b0, 1'b0);
    run_mf(0, 512, 1'b0, 3'd0, 1'b1, ecrc(2'b11), -1, 1'b0, 1'b0);

    // Disable mid-multiframe keeps the buffer; next start is idle without pop or underflow
    push(3'd2, 1'b1);
    push(3'd4, 1'b1);
    run_mf(0, 512, 1'b1, 3'd2, 1'b0, ecrc(2'b11), 100, 1'b0, 1'b0);
    run_mf(0, 512, 1'b0, 3'd0, 1'b0, ecrc(2'b11), -1, 1'b0, 1'b0);
    ctrl_enable = 1'b1;

    // CRC result coincident with the capture: old value captured, new result seeds accumulator
    rx_pulse(1'b1);
    run_mf(0, 512, 1'b1, 3'd4, 1'b0, ecrc(2'b10), -1, 1'b1, 1'b1);
    run_mf(0, 512, 1'b0, 3'd0, 1'b1, ecrc(2'b10), -1, 1'b0, 1'b0);

    // Reset mid-buffer discards active buffer and queue, no done pulse afterwards
    push(3'd5, 1'b1);
    push(3'd6, 1'b1);
    run_mf(0, 40, 1'b1, 3'd5, 1'b0, ecrc(2'b11), -1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    $display("mid-buffer reset checked");
    @(negedge clk);
    rst = 1'b0;
    run_mf(40, 472, 1'b0, 3'd0, 1'b0, 2'b11, -1, 1'b0, 1'b0);
    run_mf(0, 512, 1'b0, 3'd0, 1'b1, 2'b11, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
